// File: rtl/lu_pkg.sv
`default_nettype none
//==== lu_pkg : opcodes and FSM encoding shared by the logic unit arbiter, rev 1.0
package lu_pkg;

  localparam logic [1:0] LU_XOR = 2'b00;
  localparam logic [1:0] LU_AND = 2'b01;
  localparam logic [1:0] LU_OR  = 2'b10;
  localparam logic [1:0] LU_NOT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } lu_state_e;

endpackage
`default_nettype wire

// File: rtl/logic_unit_arbiter_if.sv
`default_nettype none
//==== logic_unit_arbiter_if : two request channels and one response channel, rev 1.0
interface logic_unit_arbiter_if #(
  parameter int WIDTH = 16
) ();

  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result
  );

endinterface
`default_nettype wire

// File: rtl/logic_unit_core.sv
`default_nettype none
//==== logic_unit_core : combinational WIDTH-bit XOR/AND/OR/NOT unit, rev 1.0
module logic_unit_core
  import lu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] out_o
);

  always_comb begin
    out_o = '0;
    case (op_i)
      LU_XOR:  out_o = a_i ^ b_i;
      LU_AND:  out_o = a_i & b_i;
      LU_OR:   out_o = a_i | b_i;
      LU_NOT:  out_o = ~a_i;
      default: out_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
//==== logic_unit_arbiter : round-robin sharing of one logic unit by two requesters, rev 1.0
//==== LU_ZERO_FLAG_EN adds a registered rsp_zero_o flag alongside the result
module logic_unit_arbiter
  import lu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  logic_unit_arbiter_if.slave bus,
  output logic [CNT_W-1:0]   op_cnt_o
`ifdef LU_ZERO_FLAG_EN
  ,
  output logic               rsp_zero_o
`endif
);

  lu_state_e        state_q, state_d;
  logic             last_q;
  logic             gnt_valid, gnt_id;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic [WIDTH-1:0] result_q;
  logic             rsp_id_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] core_out;
  logic             rsp_hs;

  // Tie goes to the requester not served last; last_q resets to 1 so REQ0 wins first.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = ~last_q;
      end else if (bus.req0_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end else if (bus.req1_valid) begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req0_ready = gnt_valid && !gnt_id;
  assign bus.req1_ready = gnt_valid && gnt_id;
  assign bus.rsp_valid  = (state_q == S_RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = result_q;
  assign op_cnt_o       = cnt_q;
  assign rsp_hs         = bus.rsp_valid && bus.rsp_ready;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .out_o (core_out)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
      rsp_id_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_valid) begin
        last_q <= gnt_id;
        id_q   <= gnt_id;
        op_q   <= gnt_id ? bus.req1_op : bus.req0_op;
        a_q    <= gnt_id ? bus.req1_a  : bus.req0_a;
        b_q    <= gnt_id ? bus.req1_b  : bus.req0_b;
      end
      if (state_q == S_EXEC) begin
        result_q <= core_out;
        rsp_id_q <= id_q;
      end
      if (rsp_hs) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef LU_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      zero_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      zero_q <= (core_out == '0);
    end
  end

  assign rsp_zero_o = zero_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
//==== tb_logic_unit_arbiter : directed self-checking bench for logic_unit_arbiter, rev 1.0
module tb_logic_unit_arbiter;
  import lu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] op_cnt;
  logic [3:0] exp_cnt;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  logic       zero_cap;
`ifdef LU_ZERO_FLAG_EN
  logic       rsp_zero;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic_unit_arbiter_if #(.WIDTH(16)) bus ();

  logic_unit_arbiter #(.WIDTH(16), .CNT_W(4)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .bus      (bus.slave),
    .op_cnt_o (op_cnt)
`ifdef LU_ZERO_FLAG_EN
    ,
    .rsp_zero_o (rsp_zero)
`endif
  );

  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp_ready  = 1;
  endtask

  // Issues one lone request and waits for its response; ends at a negedge in IDLE.
  task automatic run_op(input logic id, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, output logic [15:0] res, output logic rid,
                        output logic to);
    int t;
    bus.rsp_ready = 1;
    if (id) begin
      bus.req1_valid = 1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    t = 0;
    while (bus.rsp_valid !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    to  = (t >= 10);
    res = bus.rsp_result;
    rid = bus.rsp_id;
`ifdef LU_ZERO_FLAG_EN
    zero_cap = rsp_zero;
`else
    zero_cap = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_id !== 1'b0) $display("FAIL reset_rsp_id: got %b expected 0", bus.rsp_id); else n_pass++;
    n_checks++; if (bus.rsp_result !== 16'h0000) $display("FAIL reset_rsp_result: got %h expected 0000", bus.rsp_result); else n_pass++;
    n_checks++; if (op_cnt !== 4'h0) $display("FAIL reset_op_cnt: got %0d expected 0", op_cnt); else n_pass++;
`ifdef LU_ZERO_FLAG_EN
    n_checks++; if (rsp_zero !== 1'b0) $display("FAIL reset_rsp_zero: got %b expected 0", rsp_zero); else n_pass++;
`endif
    rst_n   = 1;
    exp_cnt = 0;
  endtask

  task automatic test_back_to_back();
    int prev;
    int t;
    logic        exp_id;
    logic [15:0] exp_res;
    prev = 0;
    bus.rsp_ready  = 1;
    bus.req0_valid = 1; bus.req0_op = LU_AND; bus.req0_a = 16'h1234; bus.req0_b = 16'h00FF;
    bus.req1_valid = 1; bus.req1_op = LU_OR;  bus.req1_a = 16'h1200; bus.req1_b = 16'h0034;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (bus.rsp_valid !== 1'b1 && t < 10) begin
        @(negedge clk);
        t++;
      end
      n_checks++; if (t >= 10) $display("FAIL b2b_timeout: got no rsp_valid within %0d cycles expected response %0d", t, k); else n_pass++;
      exp_id  = (k % 2) == 1;
      exp_res = exp_id ? 16'h1234 : 16'h0034;
      n_checks++; if (bus.rsp_id !== exp_id) $display("FAIL b2b_id[%0d]: got %b expected %b", k, bus.rsp_id, exp_id); else n_pass++;
      n_checks++; if (bus.rsp_result !== exp_res) $display("FAIL b2b_result[%0d]: got %h expected %h", k, bus.rsp_result, exp_res); else n_pass++;
      if (k > 0) begin
        n_checks++; if (cyc - prev !== 3) $display("FAIL b2b_interval[%0d]: got %0d expected 3", k, cyc - prev); else n_pass++;
      end
      prev = cyc;
      exp_cnt++;
      if (k == 3) begin
        bus.req0_valid = 0;
        bus.req1_valid = 0;
      end
      @(negedge clk);
    end
    n_checks++; if (op_cnt !== exp_cnt) $display("FAIL b2b_op_cnt: got %0d expected %0d", op_cnt, exp_cnt); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL b2b_idle: got rsp_valid %b expected 0", bus.rsp_valid); else n_pass++;
  endtask

  task automatic test_single();
    bus.rsp_ready  = 1;
    bus.req0_valid = 1; bus.req0_op = LU_XOR; bus.req0_a = 16'hFF00; bus.req0_b = 16'h0FF0;
    #1;
    n_checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
      $display("FAIL single_ready: got r0=%b r1=%b expected r0=1 r1=0", bus.req0_ready, bus.req1_ready); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 0;
    bus.req0_a     = 16'h0000;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_exec_valid: got %b expected 0", bus.rsp_valid); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL single_rsp_valid: got %b expected 1", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_result !== 16'hF0F0) $display("FAIL single_result: got %h expected f0f0", bus.rsp_result); else n_pass++;
    n_checks++; if (bus.rsp_id !== 1'b0) $display("FAIL single_id: got %b expected 0", bus.rsp_id); else n_pass++;
    @(negedge clk);
    exp_cnt++;
    n_checks++; if (op_cnt !== exp_cnt) $display("FAIL single_op_cnt: got %0d expected %0d", op_cnt, exp_cnt); else n_pass++;
  endtask

  task automatic test_backpressure();
    bus.rsp_ready  = 0;
    bus.req1_valid = 1; bus.req1_op = LU_NOT; bus.req1_a = 16'hAAAA; bus.req1_b = 16'h5555;
    #1;
    n_checks++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0)
      $display("FAIL bp_grant: got r0=%b r1=%b expected r0=0 r1=1", bus.req0_ready, bus.req1_ready); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    bus.req1_valid = 0;
    bus.req1_a     = 16'h0F0F;
    bus.req0_valid = 1; bus.req0_op = LU_XOR; bus.req0_a = 16'h1111; bus.req0_b = 16'h2222;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'h5555 || bus.rsp_id !== 1'b1 ||
          bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
        $display("FAIL bp_hold[%0d]: got v=%b res=%h id=%b r0=%b r1=%b expected v=1 res=5555 id=1 r0=0 r1=0",
                 i, bus.rsp_valid, bus.rsp_result, bus.rsp_id, bus.req0_ready, bus.req1_ready);
      else n_pass++;
      if (i < 4) @(negedge clk);
    end
    bus.rsp_ready = 1;
    @(negedge clk);
    bus.req0_valid = 0;
    exp_cnt++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL bp_release: got rsp_valid %b expected 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (op_cnt !== exp_cnt) $display("FAIL bp_op_cnt: got %0d expected %0d", op_cnt, exp_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_exec();
    bus.rsp_ready  = 1;
    bus.req0_valid = 1; bus.req0_op = LU_AND; bus.req0_a = 16'hFFFF; bus.req0_b = 16'h00FF;
    @(posedge clk);
    @(negedge clk);
    bus.req0_valid = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n   = 1;
    exp_cnt = 0;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_exec_valid: got %b expected 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (op_cnt !== exp_cnt) $display("FAIL rst_exec_op_cnt: got %0d expected %0d", op_cnt, exp_cnt); else n_pass++;
    n_checks++; if (bus.rsp_result !== 16'h0000) $display("FAIL rst_exec_result: got %h expected 0000", bus.rsp_result); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_exec_no_rsp: got %b expected 0", bus.rsp_valid); else n_pass++;
    bus.req0_valid = 1;
    bus.req1_valid = 1;
    #1;
    n_checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
      $display("FAIL rst_exec_tie: got r0=%b r1=%b expected r0=1 r1=0", bus.req0_ready, bus.req1_ready); else n_pass++;
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [15:0] res;
    logic [15:0] exp_res;
    logic        rid;
    logic        to;
    for (int i = 0; i < 16; i++) begin
      run_op(1'b1, LU_OR, 16'(i), 16'(i << 4), res, rid, to);
      exp_cnt++;
      exp_res = 16'(i) | 16'(i << 4);
      if (i == 14) begin
        n_checks++; if (op_cnt !== 4'hF) $display("FAIL wrap_preload: got %0d expected 15", op_cnt); else n_pass++;
        n_checks++; if (to !== 1'b0) $display("FAIL wrap_timeout: got timeout %b expected 0", to); else n_pass++;
      end
      if (i == 15) begin
        n_checks++; if (op_cnt !== 4'h0) $display("FAIL wrap_to_zero: got %0d expected 0", op_cnt); else n_pass++;
        n_checks++; if (res !== exp_res || rid !== 1'b1)
          $display("FAIL wrap_result: got %h id %b expected %h id 1", res, rid, exp_res); else n_pass++;
      end
    end
  endtask

`ifdef LU_ZERO_FLAG_EN
  task automatic test_zero_flag();
    logic [15:0] res;
    logic        rid;
    logic        to;
    run_op(1'b0, LU_XOR, 16'h5A5A, 16'h5A5A, res, rid, to);
    n_checks++; if (res !== 16'h0000 || zero_cap !== 1'b1 || to !== 1'b0)
      $display("FAIL zero_set: got res=%h zero=%b to=%b expected res=0000 zero=1 to=0", res, zero_cap, to); else n_pass++;
    run_op(1'b0, LU_OR, 16'h0001, 16'h0000, res, rid, to);
    n_checks++; if (res !== 16'h0001 || zero_cap !== 1'b0 || to !== 1'b0)
      $display("FAIL zero_clear: got res=%h zero=%b to=%b expected res=0001 zero=0 to=0", res, zero_cap, to); else n_pass++;
  endtask
`endif

  initial begin
    zero_cap = 1'b0;
    exp_cnt  = 0;
    test_reset();
    @(negedge clk);
    test_back_to_back();
    test_single();
    test_backpressure();
    test_reset_mid_exec();
    test_wrap();
`ifdef LU_ZERO_FLAG_EN
    test_zero_flag();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
